pol_map_fetch: RTL
==================

# pol_map_fetch

Map-fetch stage directly upstream of the pooling core. On a start pulse it reads the packed neighbour-index map (Np points × K indices) from the global buffer, unpacks each SRAM word into a serial index stream and feeds the pooling core's index port. It flags the last index of every point and drives the core's local reset at the start of each layer.

## Interface
Parameters:
- IDX_WIDTH, 10, width of one neighbour index
- SRAM_WIDTH, 64, width of one global-buffer map word
- ADDR_WIDTH, 16, global-buffer word address width
- POOL_MAP_DEPTH_WIDTH, 5, width of K
- IPW (local), SRAM_WIDTH/IDX_WIDTH (floor), indices per word; indices are packed LSB-first and upper spare bits are ignored

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- CCUPOL_Start  in  1  one-cycle start pulse; ignored unless state is IDLE
- CCUPOL_CfgK  in  POOL_MAP_DEPTH_WIDTH  indices per point; sampled at Start
- CCUPOL_CfgNp  in  IDX_WIDTH  number of points; sampled at Start
- CCUPOL_CfgMapBase  in  ADDR_WIDTH  first map word address; sampled at Start
- POLCCU_Busy  out  1  high from the cycle after an accepted Start until Done
- POLCCU_Done  out  1  one-cycle pulse at completion
- POLGLB_MapRdAddr  out  ADDR_WIDTH  read word address
- POLGLB_MapRdAddrVld  out  1  address valid
- GLBPOL_MapRdAddrRdy  in  1  address accepted
- GLBPOL_MapRdDat  in  SRAM_WIDTH  returned word; returns in request order
- GLBPOL_MapRdDatVld  in  1  data valid
- POLGLB_MapRdDatRdy  out  1  data accepted
- POLPLC_Rst  out  1  one-cycle pooling-core reset
- POLPLC_Idx  out  IDX_WIDTH  index to the pooling core
- POLPLC_IdxVld  out  1  index valid
- POLPLC_IdxLast  out  1  qualifies Idx as the K-th index of its point
- PLCPOL_IdxRdy  in  1  pooling core ready

## Operation
- FSM: IDLE -> (Start) -> INIT -> RUN -> DONE -> IDLE.
- INIT lasts one cycle. It asserts POLPLC_Rst, clears all counters and the word buffer, and computes Total = Np*K (IDX_WIDTH+POOL_MAP_DEPTH_WIDTH bits, no truncation).
- If Total == 0, INIT goes straight to DONE. No read requests are issued and no indices are emitted.
- Address generator:
  - Keeps a request counter ReqIdx (indices covered so far) and an address register starting at CfgMapBase.
  - Asserts AddrVld while ReqIdx < Total and (outstanding + buffered words) < 2.
  - On each address handshake: address += 1 (wraps modulo 2^ADDR_WIDTH), ReqIdx += IPW, outstanding += 1.
- Word buffer:
  - 2-entry FWFT FIFO.
  - POLGLB_MapRdDatRdy = !full. The credit scheme guarantees it is never full while data is pending.
  - A data handshake pushes the word and decrements outstanding. Push and pop in the same cycle are legal.
- Unpacker:
  - Sel counter (0..IPW-1) points into the head word; Idx = head[Sel*IDX_WIDTH +: IDX_WIDTH].
  - IdxVld = !empty and state == RUN.
  - On each Idx handshake: Sel += 1, Emit += 1, Kcnt += 1.
  - The head word is popped and Sel reset to 0 when Sel == IPW-1, or when Emit == Total-1 (the final word may be partially used).
- IdxLast = (Kcnt == K-1). On a handshake with IdxLast, Kcnt returns to 0. Points may straddle word boundaries.
- The handshake of index Total-1 moves RUN -> DONE. DONE pulses POLCCU_Done for one cycle and returns to IDLE.
- rst at any time: all state returns to IDLE and the FIFO is emptied. Data returning later is the environment's responsibility (the global buffer is reset together with this block).

## Timing
- Reset values: all outputs 0. The FSM is in IDLE.
- Start at cycle t: POLPLC_Rst and Busy go high at t+1. The first AddrVld is at t+2.
- Data handshake at cycle d into an empty FIFO: IdxVld rises at d+1.
- Sustained rate is 1 index/cycle with zero-latency read data and Rdy held high.
- Idx, IdxVld and IdxLast are held stable while IdxVld && !IdxRdy.
- Done is coincident with Busy falling, one cycle after the last index handshake.

## Test plan
- K=4, Np=3, SRAM_WIDTH=64 (IPW=6), base=0x0100, all Rdy high -> exactly 2 addresses (0x0100, 0x0101); 12 indices in packed order; IdxLast on indices 3, 7, 11; one Done pulse.
- Same config with PLCPOL_IdxRdy toggling 1-0-1 every cycle -> identical index/Last sequence, outputs held during stalls, no FIFO overflow, at most 2 words outstanding+buffered.
- K=5, Np=1 -> 1 address, indices 0-4 of the word emitted, Last on the 5th, word slot 5 discarded, Done.
- K=0 or Np=0 with Start -> POLPLC_Rst pulse, no AddrVld, Done two cycles after Start.
- Start while Busy -> ignored, config unchanged, sequence completes normally.
- rst asserted mid-RUN after 5 indices -> all outputs 0 immediately; a new Start then replays the full sequence from the base address.

Source files
------------

// File: rtl/pol_map_fetch.sv
// -----------------------------------------------------------------------------
// pol_map_fetch
//   Map-fetch stage in front of the pooling core. On Start it reads the packed
//   neighbour-index map (Np points x K indices) from the global buffer. It
//   unpacks each map word LSB-first into a serial index stream, flags the K-th
//   index of every point, and pulses the core's local reset at layer start.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   CCUPOL_Start/Cfg*            start pulse and layer config (K, Np, map base)
//   POLCCU_Busy/Done             status back to the controller
//   POLGLB_MapRdAddr*/GLBPOL_*   map-word read request / returned data
//   POLPLC_Rst/Idx*/PLCPOL_*     pooling-core reset and index stream
// -----------------------------------------------------------------------------
module pol_map_fetch #(
    parameter int IDX_WIDTH            = 10,
    parameter int SRAM_WIDTH           = 64,
    parameter int ADDR_WIDTH           = 16,
    parameter int POOL_MAP_DEPTH_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            CCUPOL_Start,
    input  logic [POOL_MAP_DEPTH_WIDTH-1:0] CCUPOL_CfgK,
    input  logic [IDX_WIDTH-1:0]            CCUPOL_CfgNp,
    input  logic [ADDR_WIDTH-1:0]           CCUPOL_CfgMapBase,
    output logic                            POLCCU_Busy,
    output logic                            POLCCU_Done,
    output logic [ADDR_WIDTH-1:0]           POLGLB_MapRdAddr,
    output logic                            POLGLB_MapRdAddrVld,
    input  logic                            GLBPOL_MapRdAddrRdy,
    input  logic [SRAM_WIDTH-1:0]           GLBPOL_MapRdDat,
    input  logic                            GLBPOL_MapRdDatVld,
    output logic                            POLGLB_MapRdDatRdy,
    output logic                            POLPLC_Rst,
    output logic [IDX_WIDTH-1:0]            POLPLC_Idx,
    output logic                            POLPLC_IdxVld,
    output logic                            POLPLC_IdxLast,
    input  logic                            PLCPOL_IdxRdy
);

    localparam int IPW  = SRAM_WIDTH / IDX_WIDTH;
    localparam int SELW = (IPW > 1) ? $clog2(IPW) : 1;
    localparam int TW   = IDX_WIDTH + POOL_MAP_DEPTH_WIDTH;

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t                          state, state_nxt;
    logic [POOL_MAP_DEPTH_WIDTH-1:0] cfg_k;
    logic [IDX_WIDTH-1:0]            cfg_np;
    logic [ADDR_WIDTH-1:0]           addr;
    logic [TW-1:0]                   total;
    logic [TW-1:0]                   emit;
    logic [TW:0]                     req_idx;   // one spare bit: may overshoot total by < IPW
    logic [1:0]                      outst;
    logic [1:0]                      cnt;
    logic [SRAM_WIDTH-1:0]           mem [2];
    logic                            wr_ptr, rd_ptr;
    logic [SELW-1:0]                 sel;
    logic [POOL_MAP_DEPTH_WIDTH-1:0] kcnt;
    logic [IDX_WIDTH-1:0]            lanes [IPW];

    logic [TW-1:0] total_calc;
    logic          addr_hs, push, idx_hs, pop, word_end, last_idx;

    assign total_calc = TW'(cfg_np) * TW'(cfg_k);

    // Credit check counts words in flight plus words already buffered, so the
    // 2-entry buffer can never overflow regardless of read latency.
    assign POLGLB_MapRdAddrVld = (state == RUN) && (req_idx < {1'b0, total}) &&
                                 (({1'b0, outst} + {1'b0, cnt}) < 3'd2);
    assign POLGLB_MapRdAddr    = addr;
    assign POLGLB_MapRdDatRdy  = (state == RUN) && (cnt != 2'd2);
    assign POLPLC_IdxVld       = (state == RUN) && (cnt != 2'd0);
    assign POLPLC_IdxLast      = POLPLC_IdxVld && (kcnt == cfg_k - POOL_MAP_DEPTH_WIDTH'(1));
    assign POLPLC_Rst          = (state == INIT);
    assign POLCCU_Busy         = (state == INIT) || (state == RUN);
    assign POLCCU_Done         = (state == DONE);

    assign addr_hs  = POLGLB_MapRdAddrVld && GLBPOL_MapRdAddrRdy;
    assign push     = POLGLB_MapRdDatRdy && GLBPOL_MapRdDatVld;
    assign idx_hs   = POLPLC_IdxVld && PLCPOL_IdxRdy;
    assign word_end = (sel == SELW'(IPW - 1));
    assign last_idx = (emit == total - TW'(1));
    // The final word may be only partly used; drop it after the last index.
    assign pop      = idx_hs && (word_end || last_idx);

    always_comb begin
        for (int i = 0; i < IPW; i++) begin
            lanes[i] = mem[rd_ptr][i*IDX_WIDTH +: IDX_WIDTH];
        end
    end
    assign POLPLC_Idx = lanes[sel];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CCUPOL_Start) state_nxt = INIT;
            INIT:    state_nxt = (total_calc == '0) ? DONE : RUN;
            RUN:     if (idx_hs && last_idx) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_k   <= '0;
            cfg_np  <= '0;
            addr    <= '0;
            total   <= '0;
            req_idx <= '0;
            outst   <= '0;
            cnt     <= '0;
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            sel     <= '0;
            emit    <= '0;
            kcnt    <= '0;
        end else if (state == IDLE) begin
            if (CCUPOL_Start) begin
                cfg_k  <= CCUPOL_CfgK;
                cfg_np <= CCUPOL_CfgNp;
                addr   <= CCUPOL_CfgMapBase;
            end
        end else if (state == INIT) begin
            total   <= total_calc;
            req_idx <= '0;
            outst   <= '0;
            cnt     <= '0;
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            sel     <= '0;
            emit    <= '0;
            kcnt    <= '0;
        end else begin
            if (addr_hs) begin
                addr    <= addr + ADDR_WIDTH'(1);
                req_idx <= req_idx + (TW+1)'(IPW);
            end
            case ({addr_hs, push})
                2'b10:   outst <= outst + 2'd1;
                2'b01:   outst <= outst - 2'd1;
                default: outst <= outst;
            endcase
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
            if (push) begin
                mem[wr_ptr] <= GLBPOL_MapRdDat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (idx_hs) begin
                emit <= emit + TW'(1);
                sel  <= pop ? '0 : sel + SELW'(1);
                kcnt <= POLPLC_IdxLast ? '0 : kcnt + POOL_MAP_DEPTH_WIDTH'(1);
            end
        end
    end

endmodule
